// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
package pipe_ctrl_pkg;

    // Operand source select carried through ID/EX into the EX operand muxes.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } hz_state_e;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [4:0] X0       = 5'd0;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline and the hazard controller.
// master: pipeline side (supplies hazard inputs); slave: the controller.
interface id_ex_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              ex_mc_start;
    logic              branch_taken;

    logic              pc_write_en;
    logic              if_id_write_en;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              id_ex_hold;
    logic              ex_mem_bubble;
    logic              stall_out;
    logic [1:0]        forwardA;
    logic [1:0]        forwardB;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_reg_write, mem_rd, mem_reg_write,
        output ex_mc_start, branch_taken,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        input  id_ex_hold, ex_mem_bubble, stall_out, forwardA, forwardB
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_reg_write, mem_rd, mem_reg_write,
        input  ex_mc_start, branch_taken,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        output id_ex_hold, ex_mem_bubble, stall_out, forwardA, forwardB
    );

endinterface

// File: rtl/fwd_sel_unit.sv
// Combinational forwarding-select computation for the instruction in ID.
// EX-stage producer takes priority over the MEM-stage producer; x0 never forwards.
module fwd_sel_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output fwd_sel_e          forward_a_c,
    output fwd_sel_e          forward_b_c
);

    // Select source for one operand.
    function automatic fwd_sel_e pick(input logic [REG_AW-1:0] rs, input logic use_rs);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (ex_reg_write && (ex_rd != REG_AW'(X0)) && use_rs && (rs == ex_rd))
            sel = FWD_MEM;
        else if (mem_reg_write && (mem_rd != REG_AW'(X0)) && (rs == mem_rd))
            sel = FWD_WB;
        return sel;
    endfunction

    // Both operand selects.
    always_comb begin
        forward_a_c = pick(id_rs1, id_use_rs1);
        forward_b_c = pick(id_rs2, id_use_rs2);
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX producer-side hazard controller: load-use stalls, multi-cycle EX
// occupancy, taken-branch flushes and forwarding selects.
// Optional build macro HAZARD_PERF_EN adds saturating event counters.
module id_ex_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_lu_cnt,
    output logic [31:0]        perf_mc_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MC_LAT) + 1;

    hz_state_e        state, state_nxt;
    logic [CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic             lu_c;
    fwd_sel_e         fwd_a_c, fwd_b_c;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd (
        .id_rs1        (hz.id_rs1),
        .id_rs2        (hz.id_rs2),
        .id_use_rs1    (hz.id_use_rs1),
        .id_use_rs2    (hz.id_use_rs2),
        .ex_rd         (hz.ex_rd),
        .ex_reg_write  (hz.ex_reg_write),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .forward_a_c   (fwd_a_c),
        .forward_b_c   (fwd_b_c)
    );

    // Load in EX feeding a source actually read by the instruction in ID.
    always_comb begin
        lu_c = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != '0) &&
               ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    // State and multi-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Next state: branch flush overrides everything, mc start overrides load-use.
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        if (hz.branch_taken) begin
            state_nxt  = RUN;
            mc_cnt_nxt = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_mc_start) begin
                        state_nxt  = MC_BUSY;
                        mc_cnt_nxt = CNT_W'(MC_LAT - 1);
                    end else if (lu_c) begin
                        state_nxt = LU_STALL;
                    end
                end
                LU_STALL: begin
                    if (hz.ex_mc_start) begin
                        state_nxt  = MC_BUSY;
                        mc_cnt_nxt = CNT_W'(MC_LAT - 1);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt <= CNT_W'(1)) begin
                        state_nxt  = RUN;
                        mc_cnt_nxt = '0;
                    end else begin
                        mc_cnt_nxt = mc_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt  = RUN;
                    mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Same-cycle pipeline control decode; reset forces the free-running defaults.
    always_comb begin
        hz.pc_write_en    = 1'b1;
        hz.if_id_write_en = 1'b1;
        hz.if_id_flush    = 1'b0;
        hz.id_ex_bubble   = 1'b0;
        hz.id_ex_hold     = 1'b0;
        hz.ex_mem_bubble  = 1'b0;
        hz.stall_out      = 1'b0;
        hz.forwardA       = 2'(fwd_a_c);
        hz.forwardB       = 2'(fwd_b_c);
        if (rst) begin
            hz.forwardA = 2'(FWD_REG);
            hz.forwardB = 2'(FWD_REG);
        end else if (hz.branch_taken) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (state == MC_BUSY) begin
            hz.pc_write_en    = 1'b0;
            hz.if_id_write_en = 1'b0;
            hz.id_ex_hold     = 1'b1;
            hz.ex_mem_bubble  = 1'b1;
            hz.stall_out      = 1'b1;
        end else if ((state == RUN) && lu_c) begin
            hz.pc_write_en    = 1'b0;
            hz.if_id_write_en = 1'b0;
            hz.id_ex_bubble   = 1'b1;
            hz.stall_out      = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_evt_c, mc_evt_c;

    // Event qualifiers for the performance counters.
    always_comb begin
        lu_evt_c = !hz.branch_taken && (state == RUN) && lu_c;
        mc_evt_c = (state == MC_BUSY);
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_cnt    <= '0;
            perf_mc_cnt    <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (lu_evt_c && (perf_lu_cnt != '1))
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (mc_evt_c && (perf_mc_cnt != '1))
                perf_mc_cnt <= perf_mc_cnt + 32'd1;
            if (hz.branch_taken && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_id_ex_hazard_ctrl;

    localparam int unsigned MC_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_mc_cnt, perf_flush_cnt;
`endif

    id_ex_hazard_ctrl #(.MC_LAT(MC_LAT), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_mc_cnt    (perf_mc_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remaining busy cycles of an EX multi-cycle op, and whether the
    // previous cycle inserted a load-use bubble.
    int m_busy_left = 0;
    bit m_after_lu  = 1'b0;

    function automatic bit m_lu();
        return hz.id_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic use_rs);
        if (hz.ex_reg_write && hz.ex_rd != 5'd0 && use_rs && rs == hz.ex_rd) return 2'b10;
        if (hz.mem_reg_write && hz.mem_rd != 5'd0 && rs == hz.mem_rd) return 2'b01;
        return 2'b00;
    endfunction

    // {pc, ifid_we, flush, bubble, hold, exmem_bubble, stall, fA, fB}
    function automatic logic [10:0] exp_vec();
        logic pc, ifid, fl, bub, hold, emb, st;
        logic [1:0] fa, fb;
        pc = 1; ifid = 1; fl = 0; bub = 0; hold = 0; emb = 0; st = 0;
        fa = m_fwd(hz.id_rs1, hz.id_use_rs1);
        fb = m_fwd(hz.id_rs2, hz.id_use_rs2);
        if (rst) begin
            fa = 2'b00; fb = 2'b00;
        end else if (hz.branch_taken) begin
            fl = 1; bub = 1;
        end else if (m_busy_left > 0) begin
            pc = 0; ifid = 0; hold = 1; emb = 1; st = 1;
        end else if (!m_after_lu && m_lu()) begin
            pc = 0; ifid = 0; bub = 1; st = 1;
        end
        return {pc, ifid, fl, bub, hold, emb, st, fa, fb};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {hz.pc_write_en, hz.if_id_write_en, hz.if_id_flush, hz.id_ex_bubble,
                hz.id_ex_hold, hz.ex_mem_bubble, hz.stall_out, hz.forwardA, hz.forwardB};
    endfunction

    // Advance one clock edge, stepping the model with the inputs seen at the edge.
    task automatic tick();
        int nb;
        bit na;
        nb = 0;
        na = 1'b0;
        if (rst || hz.branch_taken) begin
            nb = 0;
        end else if (m_busy_left > 0) begin
            nb = m_busy_left - 1;
        end else if (hz.ex_mc_start) begin
            nb = MC_LAT - 1;
        end else if (!m_after_lu) begin
            na = m_lu();
        end
        @(posedge clk);
        m_busy_left = nb;
        m_after_lu  = na;
        #1;
    endtask

    task automatic idle();
        hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0;
        hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rd = 0; hz.ex_mem_read = 0; hz.ex_reg_write = 0;
        hz.mem_rd = 0; hz.mem_reg_write = 0;
        hz.ex_mc_start = 0; hz.branch_taken = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        hz.id_valid = 1; hz.id_rs1 = r; hz.id_use_rs1 = 1;
        hz.ex_rd = r; hz.ex_mem_read = 1; hz.ex_reg_write = 1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); set_lu(5'd3);
        #4;
        n_tests++;
        if (hz.pc_write_en !== 1'b1 || hz.if_id_write_en !== 1'b1 || hz.stall_out !== 1'b0 ||
            hz.id_ex_bubble !== 1'b0 || hz.forwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want pc/ifid=1 others 0", obs_vec());
        end
        tick();
        rst = 0; idle();
        hz.ex_mc_start = 1; tick();
        hz.ex_mc_start = 0; tick();
        n_tests++;
        if (hz.id_ex_hold !== 1'b1) begin
            n_fail++; $display("FAIL reset_precond_busy: hold=%b want 1", hz.id_ex_hold);
        end
        rst = 1; #1;
        n_tests++;
        if (hz.id_ex_hold !== 1'b0 || hz.pc_write_en !== 1'b1) begin
            n_fail++; $display("FAIL reset_async: hold=%b pc=%b want 0/1", hz.id_ex_hold, hz.pc_write_en);
        end
        tick();
        rst = 0; hz.ex_rd = 5'd9; hz.ex_reg_write = 1; hz.id_rs1 = 5'd9;
        #3;
        n_tests++;
        if (hz.pc_write_en !== 1'b1 || hz.id_ex_hold !== 1'b0 || hz.forwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_mc: pc=%b hold=%b fA=%b want 1/0/00",
                     hz.pc_write_en, hz.id_ex_hold, hz.forwardA);
        end
        tick(); idle();
    endtask

    task automatic test_load_use();
        set_lu(5'd5);
        #4;
        n_tests++;
        if (hz.pc_write_en !== 1'b0 || hz.if_id_write_en !== 1'b0 ||
            hz.id_ex_bubble !== 1'b1 || hz.stall_out !== 1'b1) begin
            n_fail++; $display("FAIL lu_cycle1: got %b want pc=0 ifid=0 bub=1 stall=1", obs_vec());
        end
        tick();
        hz.ex_reg_write = 0; hz.mem_rd = 5'd5; hz.mem_reg_write = 1;
        #4;
        n_tests++;
        if (hz.forwardA !== 2'b01 || hz.pc_write_en !== 1'b1 || hz.if_id_write_en !== 1'b1 ||
            hz.id_ex_bubble !== 1'b0 || hz.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL lu_cycle2: got %b want fA=01 enables 1 no bubble", obs_vec());
        end
        tick(); idle();
    endtask

    task automatic test_fwd_priority();
        hz.ex_rd = 5'd7; hz.mem_rd = 5'd7; hz.ex_reg_write = 1; hz.mem_reg_write = 1;
        hz.id_rs2 = 5'd7; hz.id_use_rs2 = 1;
        #4;
        n_tests++;
        if (hz.forwardB !== 2'b10) begin
            n_fail++; $display("FAIL fwd_ex_wins: fB=%b want 10", hz.forwardB);
        end
        tick();
        hz.ex_rd = 5'd0; hz.mem_rd = 5'd0; hz.id_rs2 = 5'd0;
        #4;
        n_tests++;
        if (hz.forwardB !== 2'b00) begin
            n_fail++; $display("FAIL fwd_x0: fB=%b want 00", hz.forwardB);
        end
        tick();
        hz.ex_rd = 5'd4; hz.mem_rd = 5'd6; hz.id_rs1 = 5'd4; hz.id_use_rs1 = 0;
        #4;
        n_tests++;
        if (hz.forwardA !== 2'b00) begin
            n_fail++; $display("FAIL fwd_unused_src: fA=%b want 00", hz.forwardA);
        end
        tick(); idle();
    endtask

    task automatic test_multicycle();
        int holds;
        int late_holds;
        hz.ex_mc_start = 1;
        #4;
        n_tests++;
        if (hz.id_ex_hold !== 1'b0 || hz.pc_write_en !== 1'b1) begin
            n_fail++; $display("FAIL mc_start_cycle: hold=%b pc=%b want 0/1", hz.id_ex_hold, hz.pc_write_en);
        end
        tick();
        hz.ex_mc_start = 0;
        holds = 0;
        late_holds = 0;
        for (int c = 0; c < 10; c++) begin
            hz.ex_mc_start = (c == 1);
            #4;
            if (c < MC_LAT - 1) begin
                if (hz.id_ex_hold === 1'b1 && hz.ex_mem_bubble === 1'b1 && hz.stall_out === 1'b1) holds++;
            end else if (hz.id_ex_hold !== 1'b0 || hz.ex_mem_bubble !== 1'b0) begin
                late_holds++;
            end
            tick();
        end
        n_tests++;
        if (holds != MC_LAT - 1) begin
            n_fail++; $display("FAIL mc_busy_len: busy cycles=%0d want %0d", holds, MC_LAT - 1);
        end
        n_tests++;
        if (late_holds != 0) begin
            n_fail++; $display("FAIL mc_restart_ignored: extra busy cycles=%0d want 0", late_holds);
        end
        idle();
    endtask

    task automatic test_branch_priority();
        for (int k = 0; k < 2; k++) begin
            hz.ex_mc_start = 1; tick();
            hz.ex_mc_start = 0; tick();
            hz.branch_taken = 1;
            if (k == 1) set_lu(5'd2);
            #4;
            n_tests++;
            if (hz.if_id_flush !== 1'b1 || hz.id_ex_bubble !== 1'b1 || hz.id_ex_hold !== 1'b0 ||
                hz.pc_write_en !== 1'b1 || hz.stall_out !== 1'b0) begin
                n_fail++; $display("FAIL branch_in_mc[%0d]: got %b want flush bub, no hold/stall", k, obs_vec());
            end
            tick();
            idle();
            #4;
            n_tests++;
            if (hz.id_ex_hold !== 1'b0 || hz.pc_write_en !== 1'b1 || hz.if_id_flush !== 1'b0) begin
                n_fail++; $display("FAIL branch_then_run[%0d]: got %b want RUN idle", k, obs_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            hz.id_valid      = ($urandom_range(0, 3) != 0);
            hz.id_rs1        = 5'($urandom_range(0, 3));
            hz.id_rs2        = 5'($urandom_range(0, 3));
            hz.id_use_rs1    = 1'($urandom);
            hz.id_use_rs2    = 1'($urandom);
            hz.ex_rd         = 5'($urandom_range(0, 3));
            hz.ex_mem_read   = ($urandom_range(0, 2) == 0);
            hz.ex_reg_write  = 1'($urandom);
            hz.mem_rd        = 5'($urandom_range(0, 3));
            hz.mem_reg_write = 1'($urandom);
            hz.ex_mc_start   = ($urandom_range(0, 7) == 0);
            hz.branch_taken  = ($urandom_range(0, 11) == 0);
            #4;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        rst = 0; idle(); tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        rst = 1; idle(); tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            set_lu(5'(k + 1)); tick();
            idle(); tick();
        end
        for (int k = 0; k < 2; k++) begin
            hz.branch_taken = 1; tick();
            hz.branch_taken = 0; tick();
        end
        hz.ex_mc_start = 1; tick();
        hz.ex_mc_start = 0;
        for (int k = 0; k < MC_LAT + 1; k++) tick();
        #3;
        n_tests++;
        if (perf_lu_cnt !== 32'd3) begin
            n_fail++; $display("FAIL perf_lu: got %0d want 3", perf_lu_cnt);
        end
        n_tests++;
        if (perf_flush_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_flush: got %0d want 2", perf_flush_cnt);
        end
        n_tests++;
        if (perf_mc_cnt !== 32'(MC_LAT - 1)) begin
            n_fail++; $display("FAIL perf_mc: got %0d want %0d", perf_mc_cnt, MC_LAT - 1);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_multicycle();
        test_branch_priority();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
